// File: rtl/taus88_pkg.sv
// ============================================================================
// taus88_pkg : constants, FSM encoding and helpers for the Taus88 lane array
// Rev 1.0
// ============================================================================
`default_nettype none

package taus88_pkg;

  localparam logic [31:0] c_mask1 = 32'hFFFF_FFFE;
  localparam logic [31:0] c_mask2 = 32'hFFFF_FFF8;
  localparam logic [31:0] c_mask3 = 32'hFFFF_FFF0;

  localparam int c_s1_shl_a = 13;
  localparam int c_s1_shr   = 19;
  localparam int c_s1_shl_b = 12;
  localparam int c_s2_shl_a = 2;
  localparam int c_s2_shr   = 25;
  localparam int c_s2_shl_b = 4;
  localparam int c_s3_shl_a = 3;
  localparam int c_s3_shr   = 11;
  localparam int c_s3_shl_b = 17;

  localparam logic [31:0] c_min1 = 32'd2;
  localparam logic [31:0] c_min2 = 32'd8;
  localparam logic [31:0] c_min3 = 32'd16;

  localparam logic [31:0] c_lcg_mul = 32'd69069;
  localparam logic [31:0] c_lcg_inc = 32'd1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEED   = 2'd1,
    ST_WARMUP = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  // Lifts a seed value that would leave its component degenerate.
  function automatic logic [31:0] seed_fix(input logic [1:0] comp, input logic [31:0] v);
    logic [31:0] m;
    case (comp)
      2'd0:    m = c_min1;
      2'd1:    m = c_min2;
      default: m = c_min3;
    endcase
    return (v < m) ? v + m : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/taus88_lane.sv
// ============================================================================
// taus88_lane : one Tausworthe-88 generator (S1/S2/S3) with per-component load
// Rev 1.0
// ============================================================================
`default_nettype none

module taus88_lane
  import taus88_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_step,
  input  logic        i_load,
  input  logic [1:0]  i_load_sel,
  input  logic [31:0] i_load_data,
  output logic [31:0] o_rnd
);

  logic [31:0] r_s1, r_s2, r_s3;
  logic [31:0] w_s1_nxt, w_s2_nxt, w_s3_nxt;

  assign w_s1_nxt = ((r_s1 & c_mask1) << c_s1_shl_b) ^ (((r_s1 << c_s1_shl_a) ^ r_s1) >> c_s1_shr);
  assign w_s2_nxt = ((r_s2 & c_mask2) << c_s2_shl_b) ^ (((r_s2 << c_s2_shl_a) ^ r_s2) >> c_s2_shr);
  assign w_s3_nxt = ((r_s3 & c_mask3) << c_s3_shl_b) ^ (((r_s3 << c_s3_shl_a) ^ r_s3) >> c_s3_shr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else if (i_load) begin
      case (i_load_sel)
        2'd0:    r_s1 <= i_load_data;
        2'd1:    r_s2 <= i_load_data;
        default: r_s3 <= i_load_data;
      endcase
    end else if (i_step) begin
      r_s1 <= w_s1_nxt;
      r_s2 <= w_s2_nxt;
      r_s3 <= w_s3_nxt;
    end
  end

  assign o_rnd = r_s1 ^ r_s2 ^ r_s3;

endmodule

`default_nettype wire

// File: rtl/taus88_array.sv
// ============================================================================
// taus88_array : LANES Taus88 generators, LCG-seeded, warm-up, valid/ready out
// Optional: TAUS88_SEED_FIX_EN lifts seed values below each component minimum
// Rev 1.0
// ============================================================================
`default_nettype none

module taus88_array
  import taus88_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int WARMUP = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         seed,
  input  logic                re_seed,
  input  logic                rnd_ready,
  output logic                rnd_valid,
  output logic [32*LANES-1:0] rnd,
  output logic                busy
);

  localparam logic [3:0]  c_lane_last = 4'(LANES - 1);
  localparam logic [15:0] c_warm_last = 16'((WARMUP == 0) ? 0 : WARMUP - 1);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_x, w_x_nxt, w_load_data;
  logic [3:0]  r_lane;
  logic [1:0]  r_comp;
  logic [15:0] r_wcnt;
  logic        w_load, w_step, w_seed_last;

  // Seed write index k is tracked as (lane, component) = (k/3, k%3).
  assign w_seed_last = (r_lane == c_lane_last) && (r_comp == 2'd2);
  assign w_x_nxt     = r_x * c_lcg_mul + c_lcg_inc;

`ifdef TAUS88_SEED_FIX_EN
  assign w_load_data = seed_fix(r_comp, w_x_nxt);
`else
  assign w_load_data = w_x_nxt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    if (re_seed) begin
      w_state_nxt = ST_SEED;
    end else begin
      case (r_state)
        ST_SEED: begin
          w_load = 1'b1;
          if (w_seed_last) w_state_nxt = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
        end
        ST_WARMUP: begin
          w_step = 1'b1;
          if (r_wcnt == c_warm_last) w_state_nxt = ST_RUN;
        end
        ST_RUN:  w_step = rnd_ready;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_lane <= '0;
      r_comp <= '0;
      r_wcnt <= '0;
    end else if (re_seed) begin
      r_x    <= seed;
      r_lane <= '0;
      r_comp <= '0;
      r_wcnt <= '0;
    end else if (r_state == ST_SEED) begin
      r_x <= w_x_nxt;
      if (r_comp == 2'd2) begin
        r_comp <= '0;
        r_lane <= r_lane + 4'd1;
      end else begin
        r_comp <= r_comp + 2'd1;
      end
    end else if (r_state == ST_WARMUP) begin
      r_wcnt <= r_wcnt + 16'd1;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic w_lane_load;
    assign w_lane_load = w_load && (r_lane == 4'(gi));

    taus88_lane u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_step      (w_step),
      .i_load      (w_lane_load),
      .i_load_sel  (r_comp),
      .i_load_data (w_load_data),
      .o_rnd       (rnd[32*gi +: 32])
    );
  end

  assign rnd_valid = (r_state == ST_RUN);
  assign busy      = (r_state == ST_SEED) || (r_state == ST_WARMUP);

endmodule

`default_nettype wire

// File: tb/tb_taus88_array.sv
// ============================================================================
// tb_taus88_array : directed checks of taus88_array against a Taus88 C-style model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_taus88_array;

  logic         clk = 1'b0;
  logic         rst_n, re_seed, rnd_ready;
  logic [31:0]  seed;
  logic         v1, b1, v4, b4;
  logic [31:0]  rnd1;
  logic [127:0] rnd4;
  int           errors = 0;
  int           checks = 0;
  logic [31:0]  m_s [4][3];

  always #5 clk = ~clk;

  taus88_array #(.LANES(1), .WARMUP(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .seed(seed), .re_seed(re_seed), .rnd_ready(rnd_ready),
    .rnd_valid(v1), .rnd(rnd1), .busy(b1)
  );

  taus88_array #(.LANES(4), .WARMUP(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .seed(seed), .re_seed(re_seed), .rnd_ready(rnd_ready),
    .rnd_valid(v4), .rnd(rnd4), .busy(b4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fixv(input int c, input logic [31:0] v);
    logic [31:0] r;
    r = v;
`ifdef TAUS88_SEED_FIX_EN
    if (c == 0 && v < 2)  r = v + 2;
    if (c == 1 && v < 8)  r = v + 8;
    if (c == 2 && v < 16) r = v + 16;
`endif
    return r;
  endfunction

  task automatic model_step(input int lanes);
    logic [31:0] a, b, c;
    for (int l = 0; l < lanes; l++) begin
      a = m_s[l][0]; b = m_s[l][1]; c = m_s[l][2];
      m_s[l][0] = ((a & 32'hFFFFFFFE) << 12) ^ (((a << 13) ^ a) >> 19);
      m_s[l][1] = ((b & 32'hFFFFFFF8) << 4)  ^ (((b << 2) ^ b) >> 25);
      m_s[l][2] = ((c & 32'hFFFFFFF0) << 17) ^ (((c << 3) ^ c) >> 11);
    end
  endtask

  task automatic model_seed(input logic [31:0] sd, input int lanes, input int warm);
    logic [31:0] x;
    x = sd;
    for (int l = 0; l < lanes; l++)
      for (int c = 0; c < 3; c++) begin
        x = x * 32'd69069 + 32'd1;
        m_s[l][c] = fixv(c, x);
      end
    for (int w = 0; w < warm; w++) model_step(lanes);
  endtask

  function automatic logic [127:0] model_out4();
    logic [127:0] o;
    for (int l = 0; l < 4; l++) o[32*l +: 32] = m_s[l][0] ^ m_s[l][1] ^ m_s[l][2];
    return o;
  endfunction

  // Reseeds and waits out SEED+WARMUP; busy must span 3*4+16 cycles.
  task automatic reseed_wait(input logic [31:0] sd, input string tag);
    int n;
    seed = sd; re_seed = 1'b1; tick; re_seed = 1'b0;
    n = 0;
    while (b4 && n < 200) begin n++; tick; end
    check({tag, "_busy_cycles"}, 128'(n), 128'd28);
    check({tag, "_valid"}, 128'(v4), 128'd1);
    model_seed(sd, 4, 16);
  endtask

  task automatic check_beats(input int nb, input string tag);
    for (int i = 0; i < nb; i++) begin
      check($sformatf("%s_beat%0d", tag, i), rnd4, model_out4());
      model_step(4);
      tick;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, acc, cyc;
    logic [127:0] prev;
    logic [31:0] exp1;

    rst_n = 1'b0; re_seed = 1'b0; rnd_ready = 1'b0; seed = '0;
    tick; tick;
    check("rst_valid4", 128'(v4), 128'd0);
    check("rst_busy4",  128'(b4), 128'd0);
    check("rst_rnd4",   rnd4, 128'd0);
    check("rst_valid1", 128'(v1), 128'd0);
    check("rst_busy1",  128'(b1), 128'd0);
    check("rst_rnd1",   128'(rnd1), 128'd0);
    rst_n = 1'b1; tick;

    // Single lane, no warm-up, seed 0: S1=1 (3 with fix), S2=69070, S3=475628535.
`ifdef TAUS88_SEED_FIX_EN
    exp1 = 32'h1C588E3A;
`else
    exp1 = 32'h1C588E38;
`endif
    seed = 32'd0; re_seed = 1'b1; tick; re_seed = 1'b0;
    check("l1_busy_after_seed", 128'(b1), 128'd1);
    n = 0;
    while (!v1 && n < 20) begin n++; tick; end
    check("l1_valid_latency", 128'(n), 128'd3);
    check("l1_rnd", 128'(rnd1), 128'(exp1));
    check("l1_busy_in_run", 128'(b1), 128'd0);

    rnd_ready = 1'b1;
    reseed_wait(32'hDEADBEEF, "full");
    check_beats(64, "full");

    rnd_ready = 1'b0;
    reseed_wait(32'hDEADBEEF, "stall");
    acc = 0; cyc = 0;
    while (acc < 64 && cyc < 400) begin
      rnd_ready = 1'($urandom_range(0, 1));
      check($sformatf("stall_seq%0d", acc), rnd4, model_out4());
      prev = rnd4;
      tick;
      cyc++;
      if (rnd_ready) begin
        model_step(4);
        acc++;
      end else begin
        check("stall_hold", rnd4, prev);
      end
    end
    check("stall_accepted", 128'(acc), 128'd64);

    rnd_ready = 1'b1;
    seed = 32'h12345678; re_seed = 1'b1; tick; re_seed = 1'b0;
    repeat (5) tick;
    reseed_wait(32'hCAFEF00D, "midseed");
    check_beats(8, "midseed");

    seed = 32'h12345678; re_seed = 1'b1; tick; re_seed = 1'b0;
    repeat (17) tick;
    check("midwarm_busy", 128'(b4), 128'd1);
    reseed_wait(32'h0BADF00D, "midwarm");
    check_beats(8, "midwarm");

    rst_n = 1'b0; tick;
    check("runrst_valid", 128'(v4), 128'd0);
    check("runrst_busy",  128'(b4), 128'd0);
    check("runrst_rnd",   rnd4, 128'd0);
    rst_n = 1'b1;
    repeat (5) tick;
    check("idle_valid", 128'(v4), 128'd0);
    check("idle_busy",  128'(b4), 128'd0);
    check("idle_rnd",   rnd4, 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
